// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions: data width, reset PC, canonical NOP
// and the fetch FSM state encoding.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_FETCH = 1'b1
  } fetch_state_t;

  // Redirect targets are always word aligned; the low two bits are dropped.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage : riscv_pkg

// File: rtl/pc_register.sv
// Program counter storage: synchronous reset to RESET_PC, otherwise loads
// the next PC only when the fetch control asks for it.
module pc_register
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC_VAL = RESET_PC
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_en_i,
  input  logic [XLEN-1:0] pc_d_i,
  output logic [XLEN-1:0] pc_q_o
);

  logic [XLEN-1:0] pc_q;

  // PC register: reset dominates, then load enable, else hold.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q <= RESET_PC_VAL;
    end else if (load_en_i) begin
      pc_q <= pc_d_i;
    end
  end

  assign pc_q_o = pc_q;

endmodule : pc_register

// File: rtl/instruction_fetch_unit.sv
// IF stage of the 5-stage RV32I pipeline. Owns the PC, issues fetches to the
// instruction cache with a busy-wait handshake, applies EX-stage redirects
// (remembering ones that arrive mid-miss) and feeds the IF/ID register.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = riscv_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        STALL,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  output logic [31:0] IMEM_ADDR,
  output logic        IMEM_READ,
  input  logic [31:0] IMEM_READDATA,
  input  logic        IMEM_BUSYWAIT,
  output logic [31:0] INSTRUCTION,
  output logic [31:0] PC,
  output logic [31:0] PC_INCREMENT4,
  output logic        INSTR_VALID,
  output logic        BUSY_WAIT
);

  import riscv_pkg::*;

  fetch_state_t    state_q, state_d;
  logic            pending_q, pending_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            pc_load;

  logic            in_fetch;
  logic            done;
  logic            emit;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] target;

  assign in_fetch = (state_q == S_FETCH);
  assign done     = in_fetch && !IMEM_BUSYWAIT;
  assign pc_plus4 = pc_q + 32'd4;  // wraps modulo 2^32
  assign target   = word_align(BRANCH_TARGET);

  // A word reaches IF/ID only if it completed on the correct path and the
  // pipeline is not stalled or being redirected this cycle.
  assign emit = done && !pending_q && !BRANCH_TAKEN && !STALL && !RESET;

  pc_register #(
    .RESET_PC_VAL(RESET_PC)
  ) u_pc_register (
    .clk_i    (CLK),
    .rst_i    (RESET),
    .load_en_i(pc_load),
    .pc_d_i   (pc_d),
    .pc_q_o   (pc_q)
  );

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: one idle cycle after reset, then fetch forever.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end

  // Redirect bookkeeping registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pending_q     <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      pending_q     <= pending_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  // Next-PC selection in priority order; a redirect seen during a miss is
  // parked in redirect_pc_q and applied when the miss completes, so the
  // fall-through address is never requested.
  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    pc_load       = 1'b0;
    pc_d          = pc_q;
    pending_d     = pending_q;
    redirect_pc_d = redirect_pc_q;

    if (BRANCH_TAKEN && !done) begin
      redirect_pc_d = target;
      pending_d     = 1'b1;
    end else if (BRANCH_TAKEN && done) begin
      pc_load   = 1'b1;
      pc_d      = target;
      pending_d = 1'b0;
    end else if (pending_q && done) begin
      pc_load   = 1'b1;
      pc_d      = redirect_pc_q;
      pending_d = 1'b0;
    end else if (STALL) begin
      pc_load = 1'b0;  // re-issue the same PC next cycle
    end else if (done) begin
      pc_load = 1'b1;
      pc_d    = pc_plus4;
    end
  end

  // Outputs to the cache and the IF/ID register.
  always_comb begin
    IMEM_ADDR     = pc_q;
    IMEM_READ     = in_fetch && !RESET;
    PC            = pc_q;
    PC_INCREMENT4 = pc_plus4;
    BUSY_WAIT     = !in_fetch || IMEM_BUSYWAIT;
    INSTR_VALID   = emit;
    INSTRUCTION   = emit ? IMEM_READDATA : NOP_INSTR;
  end

endmodule : instruction_fetch_unit
